ram_fifo_ctrl: RTL

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

---
 rtl/ram_fifo_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: 16-deep byte FIFO whose storage is an external 16x8
// single-port synchronous RAM. After reset or clear, an INIT sweep writes
// zero to every RAM word, then the RUN state serves push/pop requests.
// Only one RAM access fits in a cycle, so pop wins over push.
module ram_fifo_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       push,
  input  logic [7:0] push_data,
  output logic       push_ready,
  input  logic       pop,
  output logic       pop_valid,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty,
  output logic [4:0] count,
  output logic       ram_wr,
  output logic [3:0] ram_addr,
  output logic [7:0] ram_din,
  input  logic [7:0] ram_dout
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] init_addr;
  logic [3:0] wr_ptr;
  logic [3:0] rd_ptr;
  logic [4:0] cnt;
  logic       pop_acc;
  logic       push_acc;
  logic       pop_valid_q;
  logic [7:0] last_data;

  // Next-state, acceptance decisions and the RAM command for this cycle.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so no path can leave a value unassigned and infer a latch.
    state_nxt  = state;
    pop_acc    = 1'b0;
    push_acc   = 1'b0;
    push_ready = 1'b0;
    ram_wr     = 1'b0;
    ram_addr   = rd_ptr;
    ram_din    = 8'h00;

    unique case (state)
      ST_INIT: begin
        // NOTE: the write strobe is gated by rst_n directly so the RAM sees no write while reset is held, even though INIT itself writes every cycle.
        ram_wr   = rst_n;
        ram_addr = init_addr;
        if (init_addr == 4'hF) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        pop_acc    = pop && (cnt != 5'd0) && !clear;
        push_ready = !clear && (cnt != 5'd16) && !pop_acc;
        push_acc   = push && push_ready;
        if (push_acc) begin
          ram_wr   = 1'b1;
          ram_addr = wr_ptr;
          ram_din  = push_data;
        end
      end
      default: state_nxt = ST_INIT;
    endcase

    if (clear) state_nxt = ST_INIT;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (!rst_n) state <= ST_INIT;
    else        state <= state_nxt;
  end

  // INIT sweep address: counts 0..15 during INIT, wraps back to 0 for RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          init_addr <= 4'h0;
    else if (clear || state != ST_INIT)  init_addr <= 4'h0;
    else                                 init_addr <= init_addr + 4'h1;
  end

  // FIFO pointers and occupancy; push and pop are mutually exclusive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 4'h0;
      rd_ptr <= 4'h0;
      cnt    <= 5'd0;
    end else if (clear) begin
      wr_ptr <= 4'h0;
      rd_ptr <= 4'h0;
      cnt    <= 5'd0;
    end else if (push_acc) begin
      wr_ptr <= wr_ptr + 4'h1;
      cnt    <= cnt + 5'd1;
    end else if (pop_acc) begin
      rd_ptr <= rd_ptr + 4'h1;
      cnt    <= cnt - 5'd1;
    end
  end

  // Read data arrives from the RAM one cycle after an accepted pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pop_valid_q <= 1'b0;
    else        pop_valid_q <= pop_acc;
  end

  // Remember the last popped byte so pop_data holds between pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           last_data <= 8'h00;
    else if (pop_valid_q) last_data <= ram_dout;
  end

  assign pop_valid = pop_valid_q;
  assign pop_data  = pop_valid_q ? ram_dout : last_data;
  assign count     = cnt;
  assign empty     = (cnt == 5'd0);
  assign full      = (cnt == 5'd16);

endmodule
